// File: rtl/joy_serial_reader_pkg.sv
// -----------------------------------------------------------------------------
// joy_pkg
// Shared definitions for the DB9 joystick deserialiser:
//   - frame geometry (default slot count, first/last sampled slot)
//   - joystick word bit positions for the arcade-critical buttons
//   - slot_dest(): maps a shift slot to {player, bit} in the 12-bit words
// No ports (package).
// -----------------------------------------------------------------------------
package joy_pkg;

    localparam int FRAME_SLOTS_DEF = 26;
    localparam int SLOT_FIRST      = 2;
    localparam int SLOT_LAST       = 25;

    localparam int JB_RESET = 11;
    localparam int JB_COIN  = 9;
    localparam int JB_START = 8;

    typedef enum logic {
        PLAYER1 = 1'b0,
        PLAYER2 = 1'b1
    } player_e;

    typedef struct packed {
        player_e    player;
        logic [3:0] bit_idx;
    } slot_dest_t;

    // The board shifts the low byte of each player first (start first, bit 7
    // skipped), then the four high buttons of player 2, then of player 1.
    function automatic slot_dest_t slot_dest(input logic [4:0] slot);
        slot_dest_t d;
        d.player  = PLAYER1;
        d.bit_idx = 4'd0;
        if (slot >= 5'd10 && slot <= 5'd21)
            d.player = PLAYER2;
        case (slot)
            5'd2,  5'd10: d.bit_idx = 4'(JB_START);
            5'd3,  5'd11: d.bit_idx = 4'd6;
            5'd4,  5'd12: d.bit_idx = 4'd5;
            5'd5,  5'd13: d.bit_idx = 4'd4;
            5'd6,  5'd14: d.bit_idx = 4'd3;
            5'd7,  5'd15: d.bit_idx = 4'd2;
            5'd8,  5'd16: d.bit_idx = 4'd1;
            5'd9,  5'd17: d.bit_idx = 4'd0;
            5'd18, 5'd22: d.bit_idx = 4'd10;
            5'd19, 5'd23: d.bit_idx = 4'(JB_RESET);
            5'd20, 5'd24: d.bit_idx = 4'(JB_COIN);
            5'd21, 5'd25: d.bit_idx = 4'd7;
            default:      d.bit_idx = 4'd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/joy_serial_reader_clk_gen.sv
// -----------------------------------------------------------------------------
// joy_clk_gen
// Prescaler and shift-clock generator for the joystick board.
//   clk_12   in   system clock
//   RESET_L  in   asynchronous active-low reset
//   joy_clk  out  registered 50% duty shift clock, half-period 2^DIV_LOG2
//   rise     out  one-cycle strobe in the cycle before joy_clk goes high
// -----------------------------------------------------------------------------
module joy_clk_gen #(
    parameter int DIV_LOG2 = 4
) (
    input  logic clk_12,
    input  logic RESET_L,
    output logic joy_clk,
    output logic rise
);

    logic [DIV_LOG2-1:0] presc;
    logic                wrap;

    assign wrap = &presc;
    assign rise = wrap & ~joy_clk;

    always_ff @(posedge clk_12 or negedge RESET_L) begin
        if (!RESET_L) begin
            presc   <= '0;
            joy_clk <= 1'b0;
        end else begin
            presc <= presc + 1'b1;
            if (wrap)
                joy_clk <= ~joy_clk;
        end
    end

endmodule

// File: rtl/joy_serial_reader.sv
// -----------------------------------------------------------------------------
// joy_serial_reader
// Drives the DB9 joystick shift-register board and deserialises two 12-bit
// active-low joystick words. Outputs change only at a frame commit, so a
// consumer never sees a partially captured word.
//   clk_12       in   12 MHz system clock
//   RESET_L      in   asynchronous active-low reset
//   JOY_DATA     in   serial data from the board (asynchronous)
//   JOY_CLK      out  shift clock, 50% duty
//   JOY_LOAD     out  parallel-load strobe, active low, one JOY_CLK period
//   joystick1    out  player-1 word, active low (11 reset, 9 coin, 8 start)
//   joystick2    out  player-2 word, same layout
//   frame_valid  out  one-cycle pulse with the newly committed words
// Build option: define JOY_DEBOUNCE_EN to commit a frame only when it
// matches the previous frame's capture.
// -----------------------------------------------------------------------------
module joy_serial_reader
    import joy_pkg::*;
#(
    parameter int DIV_LOG2    = 4,
    parameter int FRAME_SLOTS = FRAME_SLOTS_DEF
) (
    input  logic        clk_12,
    input  logic        RESET_L,
    input  logic        JOY_DATA,
    output logic        JOY_CLK,
    output logic        JOY_LOAD,
    output logic [11:0] joystick1,
    output logic [11:0] joystick2,
    output logic        frame_valid
);

    localparam logic [4:0] SLOT_WRAP = 5'(FRAME_SLOTS - 1);
    localparam logic [4:0] SLOT_LO   = 5'(SLOT_FIRST);
    localparam logic [4:0] SLOT_HI   = 5'(SLOT_LAST);

    logic        rise;
    logic        data_p0, data_p1;
    logic [4:0]  slot;
    logic [11:0] stage1, stage2;
    logic        commit_p1;
    logic        commit_ok;
    logic        in_window;
    slot_dest_t  dest;

    joy_clk_gen #(
        .DIV_LOG2 (DIV_LOG2)
    ) u_clk_gen (
        .clk_12  (clk_12),
        .RESET_L (RESET_L),
        .joy_clk (JOY_CLK),
        .rise    (rise)
    );

    assign dest      = slot_dest(slot);
    assign in_window = (slot >= SLOT_LO) && (slot <= SLOT_HI);

    // ---- stage 0/1: JOY_DATA synchroniser ----
    always_ff @(posedge clk_12 or negedge RESET_L) begin
        if (!RESET_L) begin
            data_p0 <= 1'b1;
            data_p1 <= 1'b1;
        end else begin
            data_p0 <= JOY_DATA;
            data_p1 <= data_p0;
        end
    end

    // ---- slot sequencing, load strobe and capture ----
    always_ff @(posedge clk_12 or negedge RESET_L) begin
        if (!RESET_L) begin
            slot      <= '0;
            JOY_LOAD  <= 1'b1;
            commit_p1 <= 1'b0;
        end else begin
            commit_p1 <= rise && (slot == SLOT_HI);
            if (rise) begin
                JOY_LOAD <= (slot != 5'd0);
                slot     <= (slot == SLOT_WRAP) ? 5'd0 : slot + 5'd1;
            end
        end
    end

    // Staging is never cleared: each frame rewrites all 24 sampled bits.
    always_ff @(posedge clk_12 or negedge RESET_L) begin
        if (!RESET_L) begin
            stage1 <= 12'hFFF;
            stage2 <= 12'hFFF;
        end else if (rise && in_window) begin
            if (dest.player == PLAYER2)
                stage2[dest.bit_idx] <= data_p1;
            else
                stage1[dest.bit_idx] <= data_p1;
        end
    end

`ifdef JOY_DEBOUNCE_EN
    logic [11:0] prev1, prev2;

    // A frame is only trusted when it repeats the previous capture.
    assign commit_ok = commit_p1 && (stage1 == prev1) && (stage2 == prev2);

    always_ff @(posedge clk_12 or negedge RESET_L) begin
        if (!RESET_L) begin
            prev1 <= 12'hFFF;
            prev2 <= 12'hFFF;
        end else if (commit_p1) begin
            prev1 <= stage1;
            prev2 <= stage2;
        end
    end
`else
    assign commit_ok = commit_p1;
`endif

    // ---- stage 2: atomic output commit ----
    always_ff @(posedge clk_12 or negedge RESET_L) begin
        if (!RESET_L) begin
            joystick1   <= 12'hFFF;
            joystick2   <= 12'hFFF;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= commit_ok;
            if (commit_ok) begin
                joystick1 <= stage1;
                joystick2 <= stage2;
            end
        end
    end

endmodule

// File: tb/tb_joy_serial_reader.sv
module tb_joy_serial_reader;

    localparam int FS = 26;

    logic        clk_12 = 1'b0;
    logic        RESET_L;
    logic        JOY_DATA;
    logic        JOY_CLK;
    logic        JOY_LOAD;
    logic [11:0] joystick1;
    logic [11:0] joystick2;
    logic        frame_valid;

    always #5 clk_12 = ~clk_12;

    joy_serial_reader #(
        .DIV_LOG2    (4),
        .FRAME_SLOTS (FS)
    ) dut (
        .clk_12      (clk_12),
        .RESET_L     (RESET_L),
        .JOY_DATA    (JOY_DATA),
        .JOY_CLK     (JOY_CLK),
        .JOY_LOAD    (JOY_LOAD),
        .joystick1   (joystick1),
        .joystick2   (joystick2),
        .frame_valid (frame_valid)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state (cycle-count based, from the frame rules)
    int          n;
    bit          chk_en;
    logic [11:0] exp_j1, exp_j2, cap1, cap2, prev1, prev2;
    logic        exp_fv, exp_clk, exp_load;
    bit          commit_pend;
    bit          drv_bit [FS];
    bit          smp     [FS];
    bit          pat     [FS];
    bit          rnd_mode;
    int          cur_slot, drv_slot;
    int          lo_map  [8];
    int          hi_map  [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at n=%0d: got %h expected %h", nm, n, act, exp);
        end
    endtask

    task automatic build_words(output logic [11:0] w1, output logic [11:0] w2);
        w1 = 12'hFFF;
        w2 = 12'hFFF;
        for (int s = 2; s <= 25; s++) begin
            int b;
            bit p2;
            if (s <= 17) begin
                b  = lo_map[(s - 2) % 8];
                p2 = (s >= 10);
            end else begin
                b  = hi_map[(s - 18) % 4];
                p2 = (s <= 21);
            end
            if (p2) w2[b] = smp[s];
            else    w1[b] = smp[s];
        end
    endtask

    task automatic model_reset();
        n           = 0;
        exp_j1      = 12'hFFF;
        exp_j2      = 12'hFFF;
        prev1       = 12'hFFF;
        prev2       = 12'hFFF;
        exp_fv      = 1'b0;
        exp_clk     = 1'b0;
        exp_load    = 1'b1;
        commit_pend = 1'b0;
        cur_slot    = -1;
        drv_slot    = 0;
    endtask

    task automatic set_pat(input bit v);
        for (int s = 0; s < FS; s++) pat[s] = v;
    endtask

    // One clk_12 cycle: advance model for posedge n, then drive the next slot's data.
    task automatic step();
        int  ns;
        bit  b;
        @(posedge clk_12);
        #1;
        exp_fv = 1'b0;
        if (commit_pend) begin
            commit_pend = 1'b0;
`ifdef JOY_DEBOUNCE_EN
            if (cap1 == prev1 && cap2 == prev2) begin
                exp_j1 = cap1;
                exp_j2 = cap2;
                exp_fv = 1'b1;
            end
            prev1 = cap1;
            prev2 = cap2;
`else
            exp_j1 = cap1;
            exp_j2 = cap2;
            exp_fv = 1'b1;
`endif
        end
        if (n % 32 == 15) begin
            cur_slot      = ((n - 15) / 32) % FS;
            smp[cur_slot] = drv_bit[cur_slot];
            if (cur_slot == 25) begin
                build_words(cap1, cap2);
                commit_pend = 1'b1;
            end
        end
        exp_clk  = (((n + 1) / 16) % 2) == 1;
        exp_load = (n >= 15 && ((n - 15) / 32) % FS == 0) ? 1'b0 : 1'b1;
        if ((n + 1) % 32 == 0) begin
            ns          = ((n + 1) / 32) % FS;
            b           = rnd_mode ? bit'($urandom_range(0, 1)) : pat[ns];
            drv_bit[ns] = b;
            JOY_DATA    = b;
            drv_slot    = ns;
        end
        n++;
    endtask

    task automatic wait_fv(input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound; i++) begin
            step();
            if (frame_valid === 1'b1) begin
                at = n - 1;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_fv: no frame_valid within %0d cycles", bound);
        end
    endtask

    task automatic wait_drv_slot(input int s);
        int i;
        for (i = 0; i < 2 * 832; i++) begin
            step();
            if (drv_slot == s) break;
        end
        chk("wait_drv_slot_reached", 32'(drv_slot), 32'(s));
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk_12);
            if (chk_en) begin
                chk("joy_clk",     32'(JOY_CLK),     32'(exp_clk));
                chk("joy_load",    32'(JOY_LOAD),    32'(exp_load));
                chk("frame_valid", 32'(frame_valid), 32'(exp_fv));
                chk("joystick1",   32'(joystick1),   32'(exp_j1));
                chk("joystick2",   32'(joystick2),   32'(exp_j2));
            end
        end
    endtask

    task automatic stimulus();
        int t1, t2, at, first_load, low_cnt, high_cnt, bad;

        lo_map = '{8, 6, 5, 4, 3, 2, 1, 0};
        hi_map = '{10, 11, 9, 7};
        set_pat(1'b1);
        rnd_mode = 1'b0;
        chk_en   = 1'b0;
        RESET_L  = 1'b0;
        JOY_DATA = 1'b1;
        model_reset();

        // Reset values
        repeat (3) @(negedge clk_12);
        chk("rst_j1",   32'(joystick1),   32'h0000_0FFF);
        chk("rst_j2",   32'(joystick2),   32'h0000_0FFF);
        chk("rst_clk",  32'(JOY_CLK),     32'd0);
        chk("rst_load", 32'(JOY_LOAD),    32'd1);
        chk("rst_fv",   32'(frame_valid), 32'd0);
        RESET_L = 1'b1;
        model_reset();
        chk_en = 1'b1;

        // First frame, load timing, period and duty
        first_load = -1;
        t1 = -1;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (first_load < 0 && JOY_LOAD === 1'b0) first_load = n - 1;
            if (frame_valid === 1'b1) begin
                t1 = n - 1;
                break;
            end
        end
        chk("first_load_edge",   32'(first_load), 32'd15);
        chk("first_commit_cyc",  32'(t1),         32'd816);
        chk("first_commit_j1",   32'(joystick1),  32'h0000_0FFF);
        chk("first_commit_j2",   32'(joystick2),  32'h0000_0FFF);
        low_cnt  = 0;
        high_cnt = 0;
        t2       = -1;
        for (int i = 0; i < 832; i++) begin
            step();
            if (JOY_LOAD === 1'b0) low_cnt++;
            if (JOY_CLK === 1'b1) high_cnt++;
            if (frame_valid === 1'b1) t2 = n - 1;
        end
        chk("fv_period",      32'(t2 - t1),  32'd832);
        chk("load_low_cycles", 32'(low_cnt), 32'd32);
        chk("clk_high_cycles", 32'(high_cnt), 32'd416);

        // Walking zero across every sampled slot
        for (int s = 2; s <= 25; s++) begin
            set_pat(1'b1);
            pat[s] = 1'b0;
            wait_fv(3 * 832, at);
            if (s == 9) begin
                chk("walk9_j1", 32'(joystick1), 32'h0000_0FFE);
                chk("walk9_j2", 32'(joystick2), 32'h0000_0FFF);
            end
            if (s == 19) begin
                chk("walk19_j1", 32'(joystick1), 32'h0000_0FFF);
                chk("walk19_j2", 32'(joystick2), 32'h0000_07FF);
            end
        end

        // Random serial data
        rnd_mode = 1'b1;
        repeat (6 * 832) step();
        rnd_mode = 1'b0;

        // Atomicity: switch from all-1 to all-0 starting at slot 12
        set_pat(1'b1);
        wait_fv(4 * 832, at);
        wait_fv(4 * 832, at);
        wait_drv_slot(11);
        set_pat(1'b0);
        wait_fv(4 * 832, at);
`ifdef JOY_DEBOUNCE_EN
        chk("atom_j1", 32'(joystick1), 32'h0000_0000);
        chk("atom_j2", 32'(joystick2), 32'h0000_0000);
`else
        chk("atom_j1", 32'(joystick1), 32'h0000_017F);
        chk("atom_j2", 32'(joystick2), 32'h0000_0140);
        wait_fv(4 * 832, at);
        chk("atom_next_j1", 32'(joystick1), 32'h0000_0000);
`endif

        // Mid-frame reset at slot 15
        for (int i = 0; i < 900; i++) begin
            step();
            if (cur_slot == 15) break;
        end
        chk("reset_slot_reached", 32'(cur_slot), 32'd15);
        @(negedge clk_12);
        chk_en  = 1'b0;
        RESET_L = 1'b0;
        #1;
        chk("midrst_j1",   32'(joystick1),   32'h0000_0FFF);
        chk("midrst_j2",   32'(joystick2),   32'h0000_0FFF);
        chk("midrst_load", 32'(JOY_LOAD),    32'd1);
        chk("midrst_clk",  32'(JOY_CLK),     32'd0);
        chk("midrst_fv",   32'(frame_valid), 32'd0);
        set_pat(1'b1);
        JOY_DATA = 1'b1;
        repeat (3) @(posedge clk_12);
        @(negedge clk_12);
        RESET_L = 1'b1;
        model_reset();
        chk_en = 1'b1;
        wait_fv(2 * 832, at);
        chk("post_rst_commit_cyc", 32'(at),        32'd816);
        chk("post_rst_j1",         32'(joystick1), 32'h0000_0FFF);

        // Single-frame glitch on slot 23 (player-1 reset button)
        wait_fv(2 * 832, at);
        pat[23] = 1'b0;
        wait_drv_slot(23);
        pat[23] = 1'b1;
`ifdef JOY_DEBOUNCE_EN
        bad = 0;
        for (int i = 0; i < 3 * 832; i++) begin
            step();
            if (joystick1 !== 12'hFFF) bad++;
        end
        chk("glitch_hidden_cycles", 32'(bad), 32'd0);
`else
        wait_fv(2 * 832, at);
        chk("glitch_seen_j1", 32'(joystick1), 32'h0000_07FF);
        wait_fv(2 * 832, at);
        chk("glitch_gone_j1", 32'(joystick1), 32'h0000_0FFF);
`endif

        // Held for two frames: reset button visible
        wait_fv(3 * 832, at);
        pat[23] = 1'b0;
        wait_fv(3 * 832, at);
        chk("held_j1", 32'(joystick1), 32'h0000_07FF);
        chk("held_j2", 32'(joystick2), 32'h0000_0FFF);
        repeat (4) step();
    endtask

    initial begin
        fork
            compare_loop();
            stimulus();
        join_any
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/joy_serial_reader.md
Name: joy_serial_reader

Overview:
- Deserialiser for the external DB9 joystick shift-register board. Drives the board's load/clock lines, samples its serial data, and delivers two 12-bit active-low joystick words (joystick1, joystick2).
- Sits directly upstream of bwidow_main and the arcade reset/coin logic in the top level. Replaces the inline shift loop there.
- Outputs update atomically once per frame, so consumers never see a half-captured word.

Parameters:
- DIV_LOG2, 4: JOY_CLK half-period is 2^DIV_LOG2 clk_12 cycles (16 cycles by default, so one JOY_CLK period is 32 cycles).
- FRAME_SLOTS, 26: JOY_CLK periods per frame. Legal range is 26..31.

Ports:
- clk_12  in  1  system clock, 12 MHz.
- RESET_L  in  1  asynchronous active-low reset.
- JOY_DATA  in  1  serial data from the shift register. Asynchronous; double-flop synchronised inside the block.
- JOY_CLK  out  1  shift clock to the board. Registered, 50% duty.
- JOY_LOAD  out  1  parallel-load strobe, active low. Registered.
- joystick1  out  12  player-1 word, active low. Bit 11 is the reset button, bit 9 coin, bit 8 start.
- joystick2  out  12  player-2 word, active low, same layout as joystick1.
- frame_valid  out  1  one-cycle pulse, asserted in the cycle the outputs commit.

Behaviour:
- Reset:
  - joystick1 = joystick2 = 12'hFFF. Released state is mandatory: joystick1[11] low resets the arcade.
  - JOY_CLK = 0, JOY_LOAD = 1, frame_valid = 0.
  - slot = 0, prescaler = 0, staging registers = 12'hFFF.
- Prescaler:
  - Counts 0..2^DIV_LOG2-1 and wraps.
  - At each wrap, JOY_CLK toggles.
  - A wrap with JOY_CLK = 0 is a "rise event" (JOY_CLK goes high on the next cycle).
- On each rise event, all in the same cycle:
  - JOY_LOAD <= 0 if slot == 0, otherwise 1.
  - If slot is in 2..25, the synchronised JOY_DATA is written into the staging bit for that slot (see Slot map).
  - slot <= 0 if slot == FRAME_SLOTS-1, otherwise slot+1.
- Slot map:
  - 2..9 → stage1 bits 8,6,5,4,3,2,1,0.
  - 10..17 → stage2 bits 8,6,5,4,3,2,1,0.
  - 18..21 → stage2 bits 10,11,9,7.
  - 22..25 → stage1 bits 10,11,9,7.
  - Slots 0, 1 and 26..FRAME_SLOTS-1 sample nothing.
- Commit:
  - Triggered by the rise event in which slot == 25 is sampled.
  - On the following cycle, joystick1 <= stage1, joystick2 <= stage2, and frame_valid = 1 for exactly one cycle.
  - Latency from the slot-25 sample edge to the new outputs is 1 clk_12 cycle.
- Timing at DIV_LOG2 = 4, FRAME_SLOTS = 26: frame_valid period is 832 cycles.
- Held inputs: constant JOY_DATA gives a constant output each frame (all-1 gives FFF, all-0 gives 000).
- Reset mid-frame:
  - All state returns to reset values immediately (asynchronous).
  - The partial frame is discarded.
  - The first commit after release comes at the end of the first complete frame.
- Staging registers are not cleared between frames: every bit is rewritten each frame.

Optional Feature:
- Macro: JOY_DEBOUNCE_EN.
- Defined:
  - A frame commits only if stage1/stage2 equal the previous frame's captured values.
  - frame_valid pulses only on a commit.
  - A single-frame glitch is never visible. Added latency is one frame.
- Undefined: every frame commits as described in Behaviour.

Decomposition:
- Package joy_pkg holds:
  - FRAME_SLOTS_DEF, SLOT_FIRST = 2, SLOT_LAST = 25.
  - The slot-to-{player, bit} map as a constant function/table.
  - Bit-index constants: JB_RESET = 11, JB_COIN = 9, JB_START = 8.
- One natural sub-module, joy_clk_gen, containing the prescaler, JOY_CLK toggle and rise-event strobe.

Test Plan:
- Reset and first frame:
  - Apply reset with JOY_DATA held 1, release it.
  - Outputs stay FFF and frame_valid stays 0 until the first commit.
  - At the first commit outputs are still FFF.
  - frame_valid then repeats every 832 cycles.
- Walking zero:
  - Drive 0 only in slot 9.
  - joystick1 = 12'hFFE, joystick2 = 12'hFFF.
  - Repeat for each slot 2..25 and check the map bit by bit (slot 19 → joystick2 = 12'h7FF).
- Load timing:
  - JOY_LOAD is low for exactly one JOY_CLK period (32 cycles) per frame.
  - The low period starts 1 cycle after the slot-0 rise event.
  - JOY_CLK has a 16/16-cycle duty.
- Atomicity:
  - Change the pattern from all-1 to all-0 mid-frame (at slot 12).
  - The next commit shows the mixed capture.
  - Outputs never change between commits.
- Mid-frame reset:
  - Assert RESET_L low at slot 15 for 3 cycles.
  - Outputs return to FFF asynchronously.
  - No frame_valid until one full frame after release.
- Debounce (JOY_DEBOUNCE_EN):
  - A one-frame 0 on slot 23 (joystick1 bit 11) produces no output change.
  - Holding it for two frames gives joystick1 = 12'h7FF at the second commit.
